inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
// - Produces OPCODE/flagbit for the Frankie control unit from its PCWrite/PCSrc/InstWrite strobes.
// - Owns PC and IR. Runs a single-outstanding req/ack fetch to instruction memory.
// - Stalls the control unit while IR cannot be loaded.
// - Sits between control_unit and the instruction memory port.
// PARAMETERS
// - ADDR_W    16   PC / imem address width
// - DATA_W    16   instruction width (fixed format below; must be 16)
// - RESET_PC  0    PC value after Reset
// - TIMEOUT   64   max cycles REQ may wait for imem_ack before error
// PORTS
// - CLK          in   1       clock, all state on posedge
// - Reset        in   1       synchronous, active-high
// - PCWrite      in   1       from control unit: update PC, launch fetch
// - PCSrc        in   3       000 = PC+1; any other value = pc_target
// - pc_target    in   ADDR_W  non-sequential next PC (datapath-muxed)
// - InstWrite    in   1       from control unit: load IR from fetched word
// - imem_req     out  1       fetch request
// - imem_addr    out  ADDR_W  fetch address, stable while imem_req=1
// - imem_ack     in   1       data valid on imem_rdata this cycle
// - imem_rdata   in   DATA_W  instruction word
// - OPCODE       out  5       IR[15:11]
// - flagbit      out  1       IR[10]
// - IMM          out  10      IR[9:0]
// - PC           out  ADDR_W  current PC
// - fetch_busy   out  1       stall: InstWrite pending, word not yet available
// - fetch_err    out  1       sticky: imem timeout
// BEHAVIOUR
// - Reset values:
//   - PC=RESET_PC; IR=0, so OPCODE/flagbit/IMM=0.
//   - imem_req=0, imem_addr=0, fetch_busy=0, fetch_err=0, buffer invalid, FSM IDLE.
// - Reset mid-transfer: imem_req drops next edge. An ack arriving in IDLE is ignored.
// - PC update on PCWrite edge:
//   - PCSrc==000: PC <= PC+1, mod 2^ADDR_W (0xFFFF wraps to 0).
//   - else: PC <= pc_target.
// - Fetch launch: every PCWrite launches a fetch of the pre-update PC value.
// - Supersede rule: a newer PCWrite always wins.
//   - Clears the buffer.
//   - Marks any outstanding request discard.
// - FSM states IDLE, REQ, DRAIN, FULL:
//   - IDLE -PCWrite-> REQ: drive imem_req=1, imem_addr=fetch addr.
//   - REQ -ack-> FULL: buffer<=imem_rdata.
//   - REQ -PCWrite, no ack-> DRAIN: req stays high and addr held (no withdrawal); new addr queued.
//   - REQ -PCWrite with ack same cycle-> REQ with the new addr; ack data dropped.
//   - DRAIN -ack-> REQ with the queued addr; data dropped. Further PCWrite only replaces the queued addr.
//   - FULL -PCWrite-> REQ. FULL -InstWrite-> IDLE: IR<=buffer.
// - Handshake: imem_req/imem_addr change only on the cycle after ack, or on Reset/timeout.
//   - A transfer completes on a cycle with imem_req=1 and imem_ack=1.
// - InstWrite timing:
//   - Buffer valid: IR loads on that edge (0-cycle stall).
//   - In REQ with ack the same cycle: bypass, IR<=imem_rdata.
//   - Otherwise: fetch_busy=1 (combinational) from that cycle until IR loads on the ack edge.
//     The pending InstWrite is remembered; the control unit holds its state.
//   - InstWrite in IDLE with nothing launched: no IR change, fetch_busy=0.
// - Timeout: wait counter clears on entering REQ/DRAIN and increments each cycle without ack.
//   - At TIMEOUT: fetch_err<=1 (sticky until Reset), imem_req<=0, FSM->IDLE, pending InstWrite cancelled.
// - Simultaneous PCWrite+InstWrite in FULL: IR loads the old buffer, then the new fetch launches.
// STRUCTURE
// - frankie_pkg holds:
//   - field constants OPC_MSB=15, OPC_LSB=11, FLAG_BIT=10, IMM_MSB=9;
//   - fetch FSM state encoding;
//   - PCSRC_SEQ=3'b000.
// - One sub-module: fetch_timeout_ctr (clear/enable/terminal-count, width $clog2(TIMEOUT+1)).
// TESTING
// - Reset, then PCWrite PCSrc=000; memory acks in 2 cycles with 0x1403.
//   -> imem_addr=0, PC=1; InstWrite -> OPCODE=00010, flagbit=1, IMM=0x003.
// - InstWrite one cycle after PCWrite, ack at cycle 4 -> fetch_busy=1 for cycles 2..4; IR loads at the cycle-4 edge.
// - PCWrite PCSrc=001, pc_target=0x0040 while REQ is outstanding.
//   -> old ack data dropped, second req addr=old PC+1 (pre-update), PC=0x0040.
// - PC=0xFFFF, PCWrite PCSrc=000 -> PC=0x0000, imem_addr=0xFFFF.
// - Never ack -> imem_req high for TIMEOUT cycles, then drops; fetch_err=1 and stays 1 until Reset.
// - Reset asserted during REQ, ack arrives next cycle -> IR stays 0, imem_req=0, PC=RESET_PC.

Source files
------------

// File: rtl/frankie_pkg.sv
// rtl/frankie_pkg.sv - shared constants and fetch FSM encoding for the Frankie fetch path
// Purpose: instruction field positions, PCSrc sequential code, fetch state type.
// Ports: none (package).
package frankie_pkg;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 11;
    localparam int FLAG_BIT = 10;
    localparam int IMM_MSB  = 9;

    localparam logic [2:0] PCSRC_SEQ = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // nothing outstanding, buffer empty
        ST_REQ   = 2'd1,  // request for the newest fetch address outstanding
        ST_DRAIN = 2'd2,  // superseded request still outstanding, newer address queued
        ST_FULL  = 2'd3   // fetched word held in buffer
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// rtl/fetch_timeout_ctr.sv - wait-cycle counter flagging an imem request that never completes
// Purpose: counts enabled cycles since the last clear; tc pulses on the enabled cycle
//          that would bring the count to TIMEOUT.
// Ports: CLK, Reset (sync, active-high), clr (restart count), en (count this cycle),
//        tc (terminal count reached).
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Firing on the last waiting cycle keeps imem_req high for exactly TIMEOUT cycles.
    assign tc = en && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC/IR owner with single-outstanding req/ack instruction fetch
// Purpose: updates PC on PCWrite, fetches the pre-update PC from imem, loads IR on
//          InstWrite and stalls the control unit (fetch_busy) until the word arrives.
// Ports: CLK, Reset (sync, active-high); PCWrite/PCSrc/pc_target/InstWrite from the
//        control unit; imem_req/imem_addr/imem_ack/imem_rdata to instruction memory;
//        OPCODE/flagbit/IMM decoded from IR; PC; fetch_busy stall; fetch_err sticky timeout.
module inst_fetch_unit
    import frankie_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              PCWrite,
    input  logic [2:0]        PCSrc,
    input  logic [ADDR_W-1:0] pc_target,
    input  logic              InstWrite,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [4:0]        OPCODE,
    output logic              flagbit,
    output logic [9:0]        IMM,
    output logic [ADDR_W-1:0] PC,
    output logic              fetch_busy,
    output logic              fetch_err
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;      // address driven on imem_addr
    logic [ADDR_W-1:0] queued_q, queued_d;  // newest address waiting behind a draining request
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              pend_q, pend_d;      // InstWrite seen but word not yet available
    logic              err_q, err_d;

    logic ack_hit;
    logic ctr_clr;
    logic ctr_tc;

    assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign imem_addr = addr_q;
    assign ack_hit   = imem_req && imem_ack;

    // Restart the wait count whenever no request is up, a transfer completes,
    // or a request is superseded (entering DRAIN).
    assign ctr_clr = !imem_req || ack_hit || ((state_q == ST_REQ) && PCWrite);

    fetch_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .CLK  (CLK),
        .Reset(Reset),
        .clr  (ctr_clr),
        .en   (imem_req && !imem_ack),
        .tc   (ctr_tc)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        queued_d = queued_q;
        buf_d    = buf_q;
        ir_d     = ir_q;
        pend_d   = pend_q;
        err_d    = err_q;

        if (PCWrite) begin
            pc_d = (PCSrc == PCSRC_SEQ) ? pc_q + 1'b1 : pc_target;
        end

        case (state_q)
            ST_IDLE: begin
                if (PCWrite) begin
                    state_d = ST_REQ;
                    addr_d  = pc_q;
                end
            end
            ST_REQ: begin
                if (ack_hit) begin
                    // Bypass: a waiting or same-cycle InstWrite takes the word straight into IR.
                    if (InstWrite || pend_q) begin
                        ir_d   = imem_rdata;
                        pend_d = 1'b0;
                    end
                    if (PCWrite) begin
                        addr_d = pc_q;
                    end else if (InstWrite || pend_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FULL;
                        buf_d   = imem_rdata;
                    end
                end else begin
                    if (InstWrite) begin
                        pend_d = 1'b1;
                    end
                    // No withdrawal: the old request stays up until acked.
                    if (PCWrite) begin
                        state_d  = ST_DRAIN;
                        queued_d = pc_q;
                    end
                end
            end
            ST_DRAIN: begin
                if (InstWrite) begin
                    pend_d = 1'b1;
                end
                if (ack_hit) begin
                    state_d = ST_REQ;
                    addr_d  = PCWrite ? pc_q : queued_q;
                end else if (PCWrite) begin
                    queued_d = pc_q;
                end
            end
            ST_FULL: begin
                if (InstWrite) begin
                    ir_d = buf_q;
                end
                if (PCWrite) begin
                    state_d = ST_REQ;
                    addr_d  = pc_q;
                end else if (InstWrite) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ctr_tc) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            err_d   = 1'b1;
        end
    end

    assign fetch_busy = pend_q ||
                        (InstWrite && (((state_q == ST_REQ) && !imem_ack) || (state_q == ST_DRAIN)));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= '0;
            queued_q <= '0;
            buf_q    <= '0;
            ir_q     <= '0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            queued_q <= queued_d;
            buf_q    <= buf_d;
            ir_q     <= ir_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign PC        = pc_q;
    assign OPCODE    = ir_q[OPC_MSB:OPC_LSB];
    assign flagbit   = ir_q[FLAG_BIT];
    assign IMM       = ir_q[IMM_MSB:0];
    assign fetch_err = err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed and randomized self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    localparam int TIMEOUT = 64;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        PCWrite = 1'b0;
    logic [2:0]  PCSrc = 3'b000;
    logic [15:0] pc_target = 16'h0000;
    logic        InstWrite = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [4:0]  OPCODE;
    logic        flagbit;
    logic [9:0]  IMM;
    logic [15:0] PC;
    logic        fetch_busy;
    logic        fetch_err;

    logic        resp_en = 1'b0;
    logic        man_ack = 1'b0;
    logic [15:0] man_rdata = 16'h0000;
    logic        rsp_ack = 1'b0;
    logic [15:0] rsp_rdata = 16'h0000;

    int n_assert = 0;
    int n_fail   = 0;

    assign imem_ack   = resp_en ? rsp_ack : man_ack;
    assign imem_rdata = resp_en ? rsp_rdata : man_rdata;

    inst_fetch_unit #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .RESET_PC(16'h0000),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .PCWrite   (PCWrite),
        .PCSrc     (PCSrc),
        .pc_target (pc_target),
        .InstWrite (InstWrite),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .OPCODE    (OPCODE),
        .flagbit   (flagbit),
        .IMM       (IMM),
        .PC        (PC),
        .fetch_busy(fetch_busy),
        .fetch_err (fetch_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] memf(logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ 16'h5A5A;
    endfunction

    // Memory model for the random phase: acks after a random 0..4 cycle wait.
    int rsp_cnt = 0;
    int rsp_dly = 0;
    always @(negedge CLK) begin
        if (resp_en && imem_req) begin
            if (rsp_cnt >= rsp_dly) begin
                rsp_ack   = 1'b1;
                rsp_rdata = memf(imem_addr);
                rsp_cnt   = 0;
                rsp_dly   = $urandom_range(0, 4);
            end else begin
                rsp_ack = 1'b0;
                rsp_cnt++;
            end
        end else begin
            rsp_ack = 1'b0;
            rsp_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ir_word();
        return {OPCODE, flagbit, IMM};
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        PCWrite = 1'b0;
        InstWrite = 1'b0;
        man_ack = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    logic [15:0] pc_m;
    logic [15:0] last_m;
    logic [15:0] ir_m;
    logic [15:0] w;
    bit          launched;
    int          n_req;

    initial begin
        // Reset state
        do_reset();
        chk("rst_pc", PC, 16'h0000);
        chk("rst_ir", ir_word(), 16'h0000);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_busy", fetch_busy, 1'b0);
        chk("rst_err", fetch_err, 1'b0);
        InstWrite = 1'b1;
        #1 chk("idle_iw_busy", fetch_busy, 1'b0);
        tick();
        InstWrite = 1'b0;
        chk("idle_iw_ir", ir_word(), 16'h0000);

        // Sequential fetch, InstWrite one cycle later, ack at cycle 4
        PCWrite = 1'b1; PCSrc = 3'b000;
        tick();
        PCWrite = 1'b0;
        chk("f1_req", imem_req, 1'b1);
        chk("f1_addr", imem_addr, 16'h0000);
        chk("f1_pc", PC, 16'h0001);
        InstWrite = 1'b1;
        #1 chk("f1_busy_c2", fetch_busy, 1'b1);
        tick();
        InstWrite = 1'b0;
        chk("f1_busy_c3", fetch_busy, 1'b1);
        tick();
        man_ack = 1'b1; man_rdata = 16'h1403;
        #1 chk("f1_busy_c4", fetch_busy, 1'b1);
        tick();
        man_ack = 1'b0;
        chk("f1_opcode", OPCODE, 5'b00010);
        chk("f1_flag", flagbit, 1'b1);
        chk("f1_imm", IMM, 10'h003);
        chk("f1_busy_after", fetch_busy, 1'b0);
        chk("f1_req_after", imem_req, 1'b0);

        // Buffered word, zero-stall InstWrite
        PCWrite = 1'b1; PCSrc = 3'b000;
        tick();
        PCWrite = 1'b0;
        chk("f2_addr", imem_addr, 16'h0001);
        man_ack = 1'b1; man_rdata = 16'hABCD;
        tick();
        man_ack = 1'b0;
        chk("f2_req_full", imem_req, 1'b0);
        chk("f2_ir_hold", ir_word(), 16'h1403);
        InstWrite = 1'b1;
        #1 chk("f2_busy", fetch_busy, 1'b0);
        tick();
        InstWrite = 1'b0;
        w = 16'hABCD;
        chk("f2_opcode", OPCODE, w[15:11]);
        chk("f2_flag", flagbit, w[10]);
        chk("f2_imm", IMM, w[9:0]);

        // Supersede while request outstanding
        PCWrite = 1'b1; PCSrc = 3'b000;
        tick();
        chk("s_addr0", imem_addr, 16'h0002);
        PCSrc = 3'b001; pc_target = 16'h0040;
        tick();
        PCWrite = 1'b0;
        chk("s_req_held", imem_req, 1'b1);
        chk("s_addr_held", imem_addr, 16'h0002);
        chk("s_pc", PC, 16'h0040);
        man_ack = 1'b1; man_rdata = 16'hDEAD;
        tick();
        chk("s_req2", imem_req, 1'b1);
        chk("s_addr2", imem_addr, 16'h0003);
        man_rdata = 16'h5000;
        tick();
        man_ack = 1'b0;
        InstWrite = 1'b1;
        tick();
        InstWrite = 1'b0;
        chk("s_ir", ir_word(), 16'h5000);

        // PC wrap and simultaneous PCWrite+InstWrite in FULL
        PCWrite = 1'b1; PCSrc = 3'b010; pc_target = 16'hFFFF;
        tick();
        PCWrite = 1'b0;
        chk("w_addr40", imem_addr, 16'h0040);
        chk("w_pcffff", PC, 16'hFFFF);
        man_ack = 1'b1; man_rdata = 16'h7777;
        tick();
        man_ack = 1'b0;
        PCWrite = 1'b1; PCSrc = 3'b000;
        tick();
        PCWrite = 1'b0;
        chk("w_pc_wrap", PC, 16'h0000);
        chk("w_addr_ffff", imem_addr, 16'hFFFF);
        man_ack = 1'b1; man_rdata = 16'h8001;
        tick();
        man_ack = 1'b0;
        PCWrite = 1'b1; PCSrc = 3'b000; InstWrite = 1'b1;
        tick();
        PCWrite = 1'b0; InstWrite = 1'b0;
        chk("pi_ir_old", ir_word(), 16'h8001);
        chk("pi_req", imem_req, 1'b1);
        chk("pi_addr", imem_addr, 16'h0000);
        chk("pi_pc", PC, 16'h0001);

        // Timeout: no ack
        n_req = imem_req ? 1 : 0;
        for (int k = 0; k < 4 * TIMEOUT && imem_req; k++) begin
            tick();
            if (imem_req) n_req++;
        end
        chk("to_req_cycles", n_req, TIMEOUT);
        chk("to_req_low", imem_req, 1'b0);
        chk("to_err", fetch_err, 1'b1);
        man_ack = 1'b1; man_rdata = 16'hFFFF;
        tick();
        man_ack = 1'b0;
        tick();
        chk("to_idle_ack_ir", ir_word(), 16'h8001);
        chk("to_idle_ack_req", imem_req, 1'b0);
        chk("to_err_sticky", fetch_err, 1'b1);

        // Reset mid-REQ with ack right after
        PCWrite = 1'b1; PCSrc = 3'b000;
        tick();
        PCWrite = 1'b0;
        chk("r_req_up", imem_req, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("r_req_drop", imem_req, 1'b0);
        man_ack = 1'b1; man_rdata = 16'h1234;
        tick();
        man_ack = 1'b0;
        chk("r_ir", ir_word(), 16'h0000);
        chk("r_req", imem_req, 1'b0);
        chk("r_pc", PC, 16'h0000);
        chk("r_err", fetch_err, 1'b0);

        // Randomized control-unit traffic against a responsive memory
        resp_en  = 1'b1;
        pc_m     = 16'h0000;
        last_m   = 16'h0000;
        ir_m     = 16'h0000;
        launched = 1'b0;
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    PCWrite   = 1'b1;
                    PCSrc     = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
                    pc_target = 16'($urandom);
                    if ($urandom_range(0, 7) == 0) pc_target = 16'hFFFF;
                    last_m    = pc_m;
                    pc_m      = (PCSrc == 3'b000) ? pc_m + 16'd1 : pc_target;
                    launched  = 1'b1;
                    tick();
                    PCWrite = 1'b0;
                    chk("rnd_pc", PC, pc_m);
                end
                1: begin
                    InstWrite = 1'b1;
                    tick();
                    InstWrite = 1'b0;
                    for (int k = 0; k < 100 && fetch_busy; k++) tick();
                    chk("rnd_busy_clear", fetch_busy, 1'b0);
                    if (launched) ir_m = memf(last_m);
                    launched = 1'b0;
                    chk("rnd_ir", ir_word(), ir_m);
                end
                default: begin
                    repeat ($urandom_range(1, 3)) tick();
                end
            endcase
        end
        chk("rnd_err", fetch_err, 1'b0);
        chk("rnd_pc_end", PC, pc_m);
        resp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
